multicycle_alu: RTL

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_alu
// Description : Handshaked ALU. Single-cycle logic/arithmetic/shift ops and
//               an iterative shift-add unsigned multiplier (WIDTH cycles)
//               producing a double-width product on result_hi/result.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_alu #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       aluSignals,
   input  logic [WIDTH-1:0] firstOperand,
   input  logic [WIDTH-1:0] secondOperand,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zeroFlag,
   output logic             carryFlag,
   output logic             overFlowFlag,
   output logic             negativeFlag,
   output logic             illegal
);

   // Opcode encoding
   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_NOT = 4'd1;
   localparam logic [3:0] OP_INC = 4'd2;
   localparam logic [3:0] OP_DEC = 4'd3;
   localparam logic [3:0] OP_MOV = 4'd4;
   localparam logic [3:0] OP_ADD = 4'd5;
   localparam logic [3:0] OP_SUB = 4'd6;
   localparam logic [3:0] OP_AND = 4'd7;
   localparam logic [3:0] OP_OR  = 4'd8;
   localparam logic [3:0] OP_SHL = 4'd9;
   localparam logic [3:0] OP_SHR = 4'd10;
   localparam logic [3:0] OP_MUL = 4'd11;

   localparam int             MSB       = WIDTH - 1;
   localparam logic [WIDTH:0] ONE_W     = 1;
   localparam int             LAST_ITER = WIDTH - 1;
   localparam logic [SHW-1:0] LAST_CNT  = LAST_ITER[SHW-1:0];

   typedef enum logic [0:0] {
      S_IDLE     = 1'b0,
      S_MUL_BUSY = 1'b1
   } state_t;

   state_t state_q, state_d;

   // Output registers
   logic [WIDTH-1:0] result_q, result_hi_q;
   logic             zero_q, carry_q, ovf_q, neg_q;
   logic             out_valid_q, illegal_q;

   // Multiplier registers: prod_q holds {partial sum, remaining multiplier}
   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [SHW-1:0]     cnt_q;

   // Single-cycle datapath
   logic [WIDTH-1:0] alu_res_d;
   logic             alu_c_d, alu_v_d, alu_upd_d, alu_ill_d;

   logic             accept;
   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   add_w, sub_w, inc_w, dec_w, shl_w, shr_w;

   // Multiplier step
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic               mul_last;

   assign in_ready = (state_q == S_IDLE);
   assign accept   = in_valid & in_ready;
   assign shamt    = secondOperand[SHW-1:0];

   assign add_w = {1'b0, firstOperand} + {1'b0, secondOperand};
   assign sub_w = {1'b0, firstOperand} - {1'b0, secondOperand};
   assign inc_w = {1'b0, firstOperand} + ONE_W;
   assign dec_w = {1'b0, firstOperand} - ONE_W;
   // Extra bit on the side the data leaves captures the last bit shifted out;
   // a zero shift leaves that bit at 0, giving carry 0 for free.
   assign shl_w = {1'b0, firstOperand} << shamt;
   assign shr_w = {firstOperand, 1'b0} >> shamt;

   assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                     (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
   assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};
   assign mul_last = (cnt_q == LAST_CNT);

   // Single-cycle result and flag computation for the presented opcode
   always_comb begin
      alu_res_d = '0;
      alu_c_d   = 1'b0;
      alu_v_d   = 1'b0;
      alu_upd_d = 1'b1;
      alu_ill_d = 1'b0;
      case (aluSignals)
         OP_NOT: alu_res_d = ~firstOperand;
         OP_INC: begin
            alu_res_d = inc_w[WIDTH-1:0];
            alu_c_d   = inc_w[WIDTH];
            alu_v_d   = ~firstOperand[MSB] & inc_w[MSB];
         end
         OP_DEC: begin
            alu_res_d = dec_w[WIDTH-1:0];
            alu_c_d   = dec_w[WIDTH];
            alu_v_d   = firstOperand[MSB] & ~dec_w[MSB];
         end
         OP_MOV: alu_res_d = firstOperand;
         OP_ADD: begin
            alu_res_d = add_w[WIDTH-1:0];
            alu_c_d   = add_w[WIDTH];
            alu_v_d   = (firstOperand[MSB] == secondOperand[MSB]) &
                        (add_w[MSB] != firstOperand[MSB]);
         end
         OP_SUB: begin
            alu_res_d = sub_w[WIDTH-1:0];
            alu_c_d   = sub_w[WIDTH];
            alu_v_d   = (firstOperand[MSB] != secondOperand[MSB]) &
                        (sub_w[MSB] != firstOperand[MSB]);
         end
         OP_AND: alu_res_d = firstOperand & secondOperand;
         OP_OR:  alu_res_d = firstOperand | secondOperand;
         OP_SHL: begin
            alu_res_d = shl_w[WIDTH-1:0];
            alu_c_d   = shl_w[WIDTH];
         end
         OP_SHR: begin
            alu_res_d = shr_w[WIDTH:1];
            alu_c_d   = shr_w[0];
         end
         OP_NOP: alu_upd_d = 1'b0;
         OP_MUL: alu_upd_d = 1'b0;
         default: begin
            alu_upd_d = 1'b0;
            alu_ill_d = 1'b1;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: enter MUL_BUSY on an accepted MUL, leave after last step
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (accept && (aluSignals == OP_MUL)) state_d = S_MUL_BUSY;
         S_MUL_BUSY: if (mul_last) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Datapath registers: output capture and multiplier iteration
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q    <= '0;
         result_hi_q <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         neg_q       <= 1'b0;
         out_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
         mcand_q     <= '0;
         prod_q      <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
         if (state_q == S_IDLE) begin
            if (accept) begin
               if (aluSignals == OP_MUL) begin
                  // Operands are latched here so later input changes are ignored
                  mcand_q <= firstOperand;
                  prod_q  <= {{WIDTH{1'b0}}, secondOperand};
                  cnt_q   <= '0;
               end else begin
                  out_valid_q <= 1'b1;
                  illegal_q   <= alu_ill_d;
                  if (alu_upd_d) begin
                     result_q    <= alu_res_d;
                     result_hi_q <= '0;
                     zero_q      <= (alu_res_d == '0);
                     neg_q       <= alu_res_d[MSB];
                     carry_q     <= alu_c_d;
                     ovf_q       <= alu_v_d;
                  end
               end
            end
         end else begin
            prod_q <= mul_next;
            cnt_q  <= cnt_q + 1'b1;
            if (mul_last) begin
               out_valid_q <= 1'b1;
               result_q    <= mul_next[WIDTH-1:0];
               result_hi_q <= mul_next[2*WIDTH-1:WIDTH];
               zero_q      <= (mul_next[WIDTH-1:0] == '0);
               neg_q       <= mul_next[MSB];
               carry_q     <= (mul_next[2*WIDTH-1:WIDTH] != '0);
               ovf_q       <= (mul_next[2*WIDTH-1:WIDTH] != '0);
            end
         end
      end
   end

   assign out_valid    = out_valid_q;
   assign illegal      = illegal_q;
   assign result       = result_q;
   assign result_hi    = result_hi_q;
   assign zeroFlag     = zero_q;
   assign carryFlag    = carry_q;
   assign overFlowFlag = ovf_q;
   assign negativeFlag = neg_q;

endmodule
`default_nettype wire
